// File: rtl/alu_req_sequencer.sv
// alu_req_sequencer: valid/ready front-end launching registered operands into a combinational ALU, with a 2-entry result FIFO; ALU_SEQ_CHECK_EN adds a reference-model check of Z.
module alu_req_sequencer #(
    parameter int ALU_LAT = 2,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [3:0]       req_inst,
    input  logic             req_sel,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [3:0]       alu_inst,
    output logic             alu_sel,
    input  logic [31:0]      alu_z,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_z,
    output logic [3:0]       rsp_inst,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             chk_err,
    output logic [15:0]      chk_err_cnt
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t           state;
    logic [3:0]       cnt;
    logic [TAG_W-1:0] tag;
    logic [31:0]      fz [2];
    logic [3:0]       fi [2];
    logic [TAG_W-1:0] ft [2];
    logic             rd, wr;
    logic [1:0]       count;
    logic             push, pop;
    assign push      = state == WAIT && cnt == 4'd0;
    assign pop       = rsp_valid && rsp_ready;
    assign req_ready = state == IDLE && count < 2'd2;
    assign rsp_valid = count != 2'd0;
    assign rsp_z     = fz[rd];
    assign rsp_inst  = fi[rd];
    assign rsp_tag   = ft[rd];
    // Accept only happens with count<2, so the slot for the eventual push is already reserved.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            tag      <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_inst <= '0;
            alu_sel  <= 1'b0;
            rd       <= 1'b0;
            wr       <= 1'b0;
            count    <= '0;
            for (int i = 0; i < 2; i++) begin
                fz[i] <= '0;
                fi[i] <= '0;
                ft[i] <= '0;
            end
        end else begin
            if (req_valid && req_ready) begin
                alu_a    <= req_a;
                alu_b    <= req_b;
                alu_inst <= req_inst;
                alu_sel  <= req_sel;
                tag      <= req_tag;
                cnt      <= 4'(ALU_LAT - 1);
                state    <= WAIT;
            end else if (state == WAIT) begin
                if (cnt != 4'd0) cnt <= cnt - 4'd1;
                else state <= IDLE;
            end
            if (push) begin
                fz[wr] <= alu_z;
                fi[wr] <= alu_inst;
                ft[wr] <= tag;
                wr     <= ~wr;
            end
            if (pop) rd <= ~rd;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
`ifdef ALU_SEQ_CHECK_EN
    logic        [31:0] exp_z;
    logic signed [31:0] sa, sb;
    assign sa = alu_a;
    assign sb = alu_b;
    always_comb begin
        case (alu_inst)
            4'd0:    exp_z = alu_a + alu_b;
            4'd1:    exp_z = -alu_a;
            4'd2:    exp_z = alu_a & alu_b;
            4'd3:    exp_z = alu_a | alu_b;
            4'd4:    exp_z = alu_a ^ alu_b;
            4'd5:    exp_z = ~alu_a;
            4'd6:    exp_z = alu_sel ? alu_b : alu_a;
            4'd7:    exp_z = alu_sel ? alu_a : alu_b;
            4'd8:    exp_z = alu_a - alu_b;
            4'd9:    exp_z = {31'b0, sa < sb};
            4'd10:   exp_z = {31'b0, sa <= sb};
            4'd11:   exp_z = {31'b0, sa > sb};
            4'd12:   exp_z = {31'b0, sa >= sb};
            4'd13:   exp_z = {31'b0, sa == sb};
            4'd14:   exp_z = {31'b0, sa != sb};
            default: exp_z = {31'b0, alu_sel ^ alu_b[0]};
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_err     <= 1'b0;
            chk_err_cnt <= '0;
        end else if (push && alu_z != exp_z) begin
            chk_err <= 1'b1;
            if (chk_err_cnt != 16'hFFFF) chk_err_cnt <= chk_err_cnt + 16'd1;
        end
    end
`else
    assign chk_err     = 1'b0;
    assign chk_err_cnt = '0;
`endif
endmodule

// File: tb/tb_alu_req_sequencer.sv
// tb_alu_req_sequencer: directed bench with an ALU stub (injectable ADD fault) and immediate-assertion checks.
module tb_alu_req_sequencer;
    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready, req_sel, alu_sel, rsp_valid, rsp_ready, chk_err, fault;
    logic [31:0] req_a, req_b, alu_a, alu_b, alu_z, rsp_z;
    logic [3:0]  req_inst, alu_inst, rsp_inst, req_tag, rsp_tag;
    logic [15:0] chk_err_cnt;
    int n_chk = 0;
    int n_fail = 0;
`ifdef ALU_SEQ_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif
    alu_req_sequencer #(.ALU_LAT(2), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_inst(req_inst), .req_sel(req_sel), .req_tag(req_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_inst(alu_inst), .alu_sel(alu_sel), .alu_z(alu_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_z(rsp_z), .rsp_inst(rsp_inst),
        .rsp_tag(rsp_tag), .chk_err(chk_err), .chk_err_cnt(chk_err_cnt)
    );
    always #5 clk = ~clk;
    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] i, input logic s);
        case (i)
            4'd0:    return a + b;
            4'd1:    return -a;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ~a;
            4'd6:    return s ? b : a;
            4'd7:    return s ? a : b;
            4'd8:    return a - b;
            4'd9:    return {31'b0, $signed(a) < $signed(b)};
            4'd10:   return {31'b0, $signed(a) <= $signed(b)};
            4'd11:   return {31'b0, $signed(a) > $signed(b)};
            4'd12:   return {31'b0, $signed(a) >= $signed(b)};
            4'd13:   return {31'b0, a == b};
            4'd14:   return {31'b0, a != b};
            default: return {31'b0, s ^ b[0]};
        endcase
    endfunction
    assign alu_z = alu_f(alu_a, alu_b, alu_inst, alu_sel) + {31'b0, fault && alu_inst == 4'd0};
    task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", t, o, e);
        end
    endtask
    task automatic setreq(input logic [31:0] a, input logic [31:0] b, input logic [3:0] i, input logic [3:0] t);
        req_a = a; req_b = b; req_inst = i; req_sel = 1'b0; req_tag = t; req_valid = 1'b1;
    endtask
    // Returns at the falling edge just after the accepting rising edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] i, input logic [3:0] t);
        setreq(a, b, i, t);
        for (int k = 0; k < 50 && !req_ready; k++) @(negedge clk);
        chk("accept_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask
    initial begin
        rst = 1'b1; fault = 1'b0; rsp_ready = 1'b0;
        req_valid = 1'b0; req_a = '0; req_b = '0; req_inst = '0; req_sel = 1'b0; req_tag = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_inst", alu_inst, 0);
        chk("rst_rsp_z", rsp_z, 0);
        chk("rst_rsp_tag", rsp_tag, 0);
        chk("rst_chk_err", chk_err, 0);
        chk("rst_chk_err_cnt", chk_err_cnt, 0);
        send(5, 7, 4'd0, 4'd3);
        chk("add_alu_a", alu_a, 5);
        chk("add_busy", req_ready, 0);
        @(negedge clk);
        chk("add_not_yet", rsp_valid, 0);
        @(negedge clk);
        chk("add_valid", rsp_valid, 1);
        chk("add_z", rsp_z, 12);
        chk("add_inst", rsp_inst, 0);
        chk("add_tag", rsp_tag, 3);
        chk("add_ready_again", req_ready, 1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("add_popped", rsp_valid, 0);
        send(10, 3, 4'd8, 4'd1);
        send(32'hF0, 32'h3C, 4'd2, 4'd2);
        setreq(1, 1, 4'd4, 4'd4);
        repeat (2) @(negedge clk);
        chk("full_ready", req_ready, 0);
        chk("full_head_z", rsp_z, 7);
        chk("full_head_tag", rsp_tag, 1);
        repeat (2) @(negedge clk);
        chk("full_held", req_ready, 0);
        chk("full_alu_a_held", alu_a, 32'hF0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("pop1_z", rsp_z, 32'h30);
        chk("pop1_tag", rsp_tag, 2);
        chk("pop1_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("third_alu_a", alu_a, 1);
        repeat (2) @(negedge clk);
        chk("third_head_still", rsp_z, 32'h30);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("pop2_valid", rsp_valid, 1);
        chk("pop2_z", rsp_z, 0);
        chk("pop2_tag", rsp_tag, 4);
        chk("pop2_inst", rsp_inst, 4);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("drained", rsp_valid, 0);
        send(32'hFFFFFFFF, 1, 4'd9, 4'd5);
        repeat (2) @(negedge clk);
        chk("altb_z", rsp_z, 1);
        send(32'hFFFFFFFF, 1, 4'd11, 4'd6);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("pushpop_valid", rsp_valid, 1);
        chk("agtb_z", rsp_z, 0);
        chk("agtb_tag", rsp_tag, 6);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("pushpop_empty", rsp_valid, 0);
        chk("clean_chk_err", chk_err, 0);
        fault = 1'b1;
        send(2, 2, 4'd0, 4'd7);
        repeat (2) @(negedge clk);
        chk("fault_z", rsp_z, 5);
        chk("fault_chk_err", chk_err, EXP_ERR);
        chk("fault_chk_cnt", chk_err_cnt, {15'b0, EXP_ERR});
        fault = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        send(1, 1, 4'd0, 4'd8);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("wrst_rsp_valid", rsp_valid, 0);
        chk("wrst_req_ready", req_ready, 1);
        chk("wrst_alu_a", alu_a, 0);
        chk("wrst_chk_err", chk_err, 0);
        repeat (3) @(negedge clk);
        chk("wrst_no_rsp", rsp_valid, 0);
        send(9, 4, 4'd8, 4'd9);
        repeat (2) @(negedge clk);
        chk("post_valid", rsp_valid, 1);
        chk("post_z", rsp_z, 5);
        chk("post_tag", rsp_tag, 9);
        chk("post_inst", rsp_inst, 8);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_req_sequencer.md
# alu_req_sequencer

Handshaked front-end that owns the operand side of the combinational 32-bit ALU. It accepts one operation per request (A, B, INST, SEL, tag) on a valid/ready channel and drives registered operands onto the ALU's A/B/INST/SEL ports. It waits a fixed number of cycles for Z to settle, then captures Z into a 2-entry response FIFO drained on a second valid/ready channel. It sits between the issue logic and the ALU, turning the ALU's multicycle combinational path into a clean synchronous interface.

## Interface
- ALU_LAT, 2, cycles from operand launch to Z capture; legal range 1..15
- TAG_W, 4, width of request/response tag
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready at rising edge
- req_a, req_b  in  32  signed operands
- req_inst  in  4  ALU opcode (0 ADD … 15 SEL^B)
- req_sel  in  1  select bit
- req_tag  in  TAG_W  opaque tag, echoed on response
- alu_a, alu_b  out  32  registered operands to ALU A/B
- alu_inst  out  4  registered opcode to ALU INST
- alu_sel  out  1  registered select to ALU SEL
- alu_z  in  32  ALU result Z
- rsp_valid  out  1  FIFO head valid
- rsp_ready  in  1  consumer takes head when rsp_valid && rsp_ready
- rsp_z  out  32  result
- rsp_inst  out  4  opcode of the result
- rsp_tag  out  TAG_W  echoed tag
- chk_err  out  1  sticky mismatch flag (see Configuration)
- chk_err_cnt  out  16  saturating mismatch count

## Operation
- FSM states: IDLE, WAIT.
- req_ready = (state==IDLE) && (fifo_count<2), combinational; no dependence on req_valid.
- IDLE, handshake: load alu_a/b/inst/sel and tag, wait counter = ALU_LAT-1, go to WAIT.
- WAIT, counter≠0: decrement. Counter==0: push {alu_z, alu_inst, tag} into FIFO, go to IDLE.
- Space for the push is guaranteed because it was reserved at accept: count only falls during WAIT.
- alu_* outputs hold the last issued operation while IDLE and change only on accept.
- FIFO: 2 entries, strict in-order. Simultaneous push and pop at count 1 leaves count 1 with the new entry at head next cycle. Pop at count 0 is impossible (rsp_valid=0).
- rsp_* show the FIFO head. They are don't-care when rsp_valid=0 but are driven from storage, not X.

## Timing
- Reset values: req_ready=1 (following cycle), rsp_valid=0, alu_a=alu_b=0, alu_inst=0, alu_sel=0, rsp_z=0, rsp_inst=0, rsp_tag=0, chk_err=0, chk_err_cnt=0. State IDLE, FIFO empty.
- Accept at edge N. alu_* valid after N. Capture at edge N+ALU_LAT. rsp_valid=1 after N+ALU_LAT if FIFO was empty.
- Next accept at edge N+ALU_LAT+1 at earliest. Sustained throughput is 1 op per ALU_LAT+1 cycles.
- Reset asserted in WAIT: in-flight operation discarded, no response produced, FIFO contents dropped.
- Reset has priority over every handshake in the same cycle.

## Configuration
- ALU_SEQ_CHECK_EN defined: a behavioural reference model computes the expected Z from the captured operands.
  - Reference model: ADD, -A, AND, OR, XOR, ~A, SEL muxes, SUB.
  - Signed compares <, <=, >, >=, ==, != yield {31'b0,bit}. Opcode 15 yields {31'b0, SEL^B[0]}.
  - At every capture, if alu_z differs from the expected value, chk_err is set and stays set until rst.
  - On a mismatch, chk_err_cnt increments and saturates at 16'hFFFF.
- Undefined: no model is built; chk_err and chk_err_cnt are constant 0.

## Test plan
- Reset: hold rst 2 cycles, release -> req_ready=1, rsp_valid=0, alu_a=0, chk_err_cnt=0.
- ALU_LAT=2, ADD A=5 B=7 tag=3 accepted at edge N -> alu_a=5 after N, rsp_valid after N+2 with rsp_z=12, rsp_inst=0, rsp_tag=3.
- rsp_ready=0, issue 3 requests (SUB 10-3, AND F0&3C, XOR 1^1) -> two captured, req_ready=0 with third held. Then rsp_ready=1 -> responses 7, 0x30, 0 in order, third accepted after first pop.
- ALTB A=0xFFFFFFFF B=1 -> rsp_z=1. AGTB same operands -> rsp_z=0.
- ALU_SEQ_CHECK_EN, ALU stub returns A+B+1 for ADD 2+2 -> chk_err=1, chk_err_cnt=1 after capture. With the macro undefined -> both remain 0.
- rst pulsed one cycle after accept in WAIT -> rsp_valid stays 0, req_ready=1 after reset, next request completes normally.
